// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the multi-channel reciprocal frequency meter.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StCount,
    StClose,
    StDone
  } chan_state_e;

  localparam int unsigned StatValid   = 0;
  localparam int unsigned StatTimeout = 1;
  localparam int unsigned StatOvf     = 2;
  localparam int unsigned StatW       = 3;

endpackage

// File: rtl/freq_meter_chan.sv
// One measurement channel: synchroniser, edge detector, gating FSM, saturating
// counters, gate/timeout timers and latched results.
module freq_meter_chan
  import freq_meter_pkg::*;
#(
  parameter int unsigned CntW       = 34,
  parameter int unsigned GateCyc    = 1000,
  parameter int unsigned TimeoutCyc = 2000,
  parameter int unsigned SyncStages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sig_i,
  input  logic             arm_i,
  input  logic             abort_i,
  output logic             done_o,
  output logic [CntW-1:0]  ref_o,
  output logic [CntW-1:0]  sig_o,
  output logic [StatW-1:0] stat_o
);

  localparam int unsigned GateW = $clog2(GateCyc + 1);
  localparam int unsigned TmoW  = $clog2(TimeoutCyc + 1);
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  chan_state_e state_q, state_d;
  logic [SyncStages-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic edge_det;
  logic [CntW-1:0] ref_q, ref_d, sig_q, sig_d;
  logic [CntW-1:0] res_ref_q, res_ref_d, res_sig_q, res_sig_d;
  logic [StatW-1:0] res_stat_q, res_stat_d;
  logic ovf_q, ovf_d;
  logic [GateW-1:0] gate_q, gate_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [CntW-1:0] ref_inc, sig_nxt;
  logic ovf_inc, gate_hit, tmo_hit, fin_ok, fin_to;

  always_comb begin
    sync_d   = {sync_q[SyncStages-2:0], sig_i};
    prev_d   = sync_q[SyncStages-1];
    edge_det = sync_q[SyncStages-1] & ~prev_q;
  end

  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    sig_d      = sig_q;
    ovf_d      = ovf_q;
    gate_d     = gate_q;
    tmo_d      = tmo_q;
    res_ref_d  = res_ref_q;
    res_sig_d  = res_sig_q;
    res_stat_d = res_stat_q;
    fin_ok     = 1'b0;
    fin_to     = 1'b0;

    // Saturating increments; ovf is sticky once any counter tries to pass the max.
    ref_inc  = (ref_q == CntMax) ? ref_q : ref_q + CntW'(1);
    sig_nxt  = (edge_det && sig_q != CntMax) ? sig_q + CntW'(1) : sig_q;
    ovf_inc  = ovf_q | (ref_q == CntMax) | (edge_det & (sig_q == CntMax));
    gate_hit = (gate_q == GateW'(GateCyc - 1));
    tmo_hit  = (tmo_q == TmoW'(TimeoutCyc - 1));

    if (abort_i) begin
      state_d = StIdle;
    end else if (arm_i) begin
      state_d = StArm;
      tmo_d   = '0;
    end else begin
      unique case (state_q)
        StArm: begin
          if (edge_det) begin
            state_d = StCount;
            ref_d   = '0;
            sig_d   = '0;
            ovf_d   = 1'b0;
            gate_d  = '0;
            tmo_d   = '0;
          end else if (tmo_hit) begin
            fin_to = 1'b1;
          end else begin
            tmo_d = tmo_q + TmoW'(1);
          end
        end
        StCount, StClose: begin
          ref_d = ref_inc;
          sig_d = sig_nxt;
          ovf_d = ovf_inc;
          tmo_d = edge_det ? '0 : tmo_q + TmoW'(1);
          if (state_q == StCount) gate_d = gate_q + GateW'(1);
          // An edge landing on the gate-expiry cycle closes the measurement at once.
          if (edge_det && (state_q == StClose || gate_hit)) begin
            fin_ok = 1'b1;
          end else if (!edge_det && tmo_hit) begin
            fin_to = 1'b1;
          end else if (state_q == StCount && gate_hit) begin
            state_d = StClose;
          end
        end
        default: ;
      endcase
    end

    if (fin_ok) begin
      state_d                 = StDone;
      res_ref_d               = ref_inc;
      res_sig_d               = sig_nxt;
      res_stat_d              = '0;
      res_stat_d[StatValid]   = 1'b1;
      res_stat_d[StatOvf]     = ovf_inc;
    end
    if (fin_to) begin
      state_d                 = StDone;
      res_ref_d               = '0;
      res_sig_d               = '0;
      res_stat_d              = '0;
      res_stat_d[StatTimeout] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      sync_q     <= '0;
      prev_q     <= 1'b0;
      ref_q      <= '0;
      sig_q      <= '0;
      ovf_q      <= 1'b0;
      gate_q     <= '0;
      tmo_q      <= '0;
      res_ref_q  <= '0;
      res_sig_q  <= '0;
      res_stat_q <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      ref_q      <= ref_d;
      sig_q      <= sig_d;
      ovf_q      <= ovf_d;
      gate_q     <= gate_d;
      tmo_q      <= tmo_d;
      res_ref_q  <= res_ref_d;
      res_sig_q  <= res_sig_d;
      res_stat_q <= res_stat_d;
    end
  end

  assign done_o = (state_q == StDone);
  assign ref_o  = res_ref_q;
  assign sig_o  = res_sig_q;
  assign stat_o = res_stat_q;

endmodule

// File: rtl/freq_meter_mc.sv
// Multi-channel reciprocal frequency meter: channel array, start/abort/cont
// arbitration, done/busy aggregation and the register-style read mux.
module freq_meter_mc
  import freq_meter_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned CNT_W       = 34,
  parameter int unsigned GATE_CYC    = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 2 * GATE_CYC,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned RD_W       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [CH-1:0]    sig_in,
  input  logic [CH-1:0]    ch_en,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  input  logic [RD_W-1:0]  rd_ch,
  output logic [CNT_W-1:0] rd_ref,
  output logic [CNT_W-1:0] rd_sig,
  output logic [StatW-1:0] rd_stat
);

  logic [CH-1:0] chan_done, arm;
  logic [CNT_W-1:0] chan_ref [CH];
  logic [CNT_W-1:0] chan_sig [CH];
  logic [StatW-1:0] chan_stat [CH];
  logic [CH-1:0] en_q, en_d;
  logic run_q, run_d, done_q, done_d;
  logic start_acc, rearm, all_done;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    freq_meter_chan #(
      .CntW      (CNT_W),
      .GateCyc   (GATE_CYC),
      .TimeoutCyc(TIMEOUT_CYC),
      .SyncStages(SYNC_STAGES)
    ) u_chan (
      .clk_i  (sys_clk),
      .rst_ni (sys_rst_n),
      .sig_i  (sig_in[g]),
      .arm_i  (arm[g]),
      .abort_i(abort),
      .done_o (chan_done[g]),
      .ref_o  (chan_ref[g]),
      .sig_o  (chan_sig[g]),
      .stat_o (chan_stat[g])
    );
  end

  assign start_acc = start & ~run_q & ~abort;
  // Continuous re-arm fires in the done cycle, so channels re-enter ARM right after it.
  assign rearm     = done_q & cont & ~abort & ~start_acc & (en_q != '0);
  assign all_done  = &(chan_done | ~en_q);

  always_comb begin
    run_d  = run_q;
    en_d   = en_q;
    done_d = 1'b0;
    arm    = '0;
    if (abort) begin
      run_d = 1'b0;
    end else if (start_acc) begin
      en_d = ch_en;
      if (ch_en == '0) begin
        done_d = 1'b1;
      end else begin
        arm   = ch_en;
        run_d = 1'b1;
      end
    end else if (rearm) begin
      arm   = en_q;
      run_d = 1'b1;
    end else if (run_q && all_done) begin
      done_d = 1'b1;
      run_d  = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      en_q   <= '0;
    end else begin
      run_q  <= run_d;
      done_q <= done_d;
      en_q   <= en_d;
    end
  end

  assign busy = run_q;
  assign done = done_q;

  always_comb begin
    rd_ref  = '0;
    rd_sig  = '0;
    rd_stat = '0;
    for (int i = 0; i < CH; i++) begin
      if (rd_ch == RD_W'(i)) begin
        rd_ref  = chan_ref[i];
        rd_sig  = chan_sig[i];
        rd_stat = chan_stat[i];
      end
    end
  end

endmodule

// File: tb/tb_freq_meter_mc.sv
// Randomised self-checking bench for freq_meter_mc against a whole-period model.
module tb_freq_meter_mc;

  localparam int Gate = 1000;
  localparam int Tmo  = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sig_in = '0;
  logic [3:0] ch_en = '0;
  logic start = 1'b0, cont = 1'b0, abort = 1'b0;
  logic busy, done;
  logic [1:0] rd_ch = '0;
  logic [33:0] rd_ref, rd_sig;
  logic [2:0] rd_stat;

  logic sig8 = 1'b0, start8 = 1'b0;
  logic [0:0] sig8_v, en8 = 1'b1, rd_ch8 = 1'b0;
  logic busy8, done8;
  logic [7:0] rd_ref8, rd_sig8;
  logic [2:0] rd_stat8;

  int per[4];
  int ph[4];
  longint unsigned exp_ref[4], exp_sig[4];
  logic [2:0] exp_stat[4];
  int errors = 0, checks = 0;

  always #10 clk = ~clk;

  freq_meter_mc #(
    .CH(4), .CNT_W(34), .GATE_CYC(Gate), .TIMEOUT_CYC(Tmo), .SYNC_STAGES(2)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .sig_in(sig_in), .ch_en(ch_en), .start(start),
    .cont(cont), .abort(abort), .busy(busy), .done(done), .rd_ch(rd_ch),
    .rd_ref(rd_ref), .rd_sig(rd_sig), .rd_stat(rd_stat)
  );

  assign sig8_v = sig8;

  freq_meter_mc #(
    .CH(1), .CNT_W(8), .GATE_CYC(Gate), .TIMEOUT_CYC(Tmo), .SYNC_STAGES(2)
  ) dut8 (
    .sys_clk(clk), .sys_rst_n(rst_n), .sig_in(sig8_v), .ch_en(en8), .start(start8),
    .cont(1'b0), .abort(1'b0), .busy(busy8), .done(done8), .rd_ch(rd_ch8),
    .rd_ref(rd_ref8), .rd_sig(rd_sig8), .rd_stat(rd_stat8)
  );

  // Test waveforms: period per[i] cycles, 0 holds the line low.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (per[i] == 0) begin
        ph[i] = 0;
        sig_in[i] = 1'b0;
      end else begin
        ph[i] = (ph[i] + 1) % per[i];
        sig_in[i] = (ph[i] < per[i] / 2);
      end
    end
    sig8 = ~sig8;
  end

  // Whole test periods: the gate closes on the first edge at or after Gate cycles.
  function automatic void predict(input int p, input int w, output longint unsigned r,
                                  output longint unsigned s, output logic [2:0] st);
    longint unsigned n, mx;
    mx = (64'd1 << w) - 1;
    if (p == 0) begin
      r = 0; s = 0; st = 3'b010;
    end else begin
      n = longint'((Gate + p - 1) / p);
      r = n * longint'(p);
      s = n;
      st = 3'b001;
      if (r > mx) begin r = mx; st[2] = 1'b1; end
      if (s > mx) begin s = mx; st[2] = 1'b1; end
    end
  endfunction

  task automatic wait_done(input int budget, output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    while (cyc < budget && !ok) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic pulse_start(input logic [3:0] en);
    ch_en = en;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (100) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b done=%b, expected 0 0", busy, done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_ref[i] = 0; exp_sig[i] = 0; exp_stat[i] = 3'b000;
      rd_ch = 2'(i);
      #1;
      checks++;
      if ({rd_ref, rd_sig, rd_stat} !== 71'd0) begin
        errors++;
        $display("FAIL reset_read ch%0d: got ref=%0d sig=%0d stat=%b, expected 0 0 000",
                 i, rd_ref, rd_sig, rd_stat);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    int cyc;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      per[0] = (k == 0) ? 10 : int'($urandom_range(40, 2));
      settle();
      predict(per[0], 34, exp_ref[0], exp_sig[0], exp_stat[0]);
      pulse_start(4'b0001);
      wait_done(3000, cyc, ok);
      checks++;
      if (!ok || busy !== 1'b0) begin
        errors++;
        $display("FAIL single_done p=%0d: got done=%b busy=%b, expected 1 0", per[0], ok, busy);
      end
      rd_ch = 2'd0;
      #1;
      checks++;
      if ({rd_ref, rd_sig, rd_stat} !== {exp_ref[0][33:0], exp_sig[0][33:0], exp_stat[0]}) begin
        errors++;
        $display("FAIL single_read p=%0d: got ref=%0d sig=%0d stat=%b, expected %0d %0d %b",
                 per[0], rd_ref, rd_sig, rd_stat, exp_ref[0], exp_sig[0], exp_stat[0]);
      end
    end
  endtask

  task automatic test_multi(input int iters);
    int cyc;
    bit ok;
    logic [3:0] en;
    for (int k = 0; k < iters; k++) begin
      if (k == 0) begin
        en = 4'b1111;
        per[0] = 10;
        per[1] = 7;
        per[2] = int'($urandom_range(40, 2));
        per[3] = int'($urandom_range(40, 2));
      end else begin
        en = 4'($urandom_range(15, 1));
        for (int i = 0; i < 4; i++) per[i] = int'($urandom_range(40, 2));
      end
      settle();
      for (int i = 0; i < 4; i++)
        if (en[i]) predict(per[i], 34, exp_ref[i], exp_sig[i], exp_stat[i]);
      pulse_start(en);
      wait_done(3000, cyc, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL multi_done en=%b: got no done within 3000 cycles, expected done", en);
      end
      for (int i = 0; i < 4; i++) begin
        rd_ch = 2'(i);
        #1;
        checks++;
        if ({rd_ref, rd_sig, rd_stat} !== {exp_ref[i][33:0], exp_sig[i][33:0], exp_stat[i]}) begin
          errors++;
          $display("FAIL multi_read en=%b ch%0d: got ref=%0d sig=%0d stat=%b, expected %0d %0d %b",
                   en, i, rd_ref, rd_sig, rd_stat, exp_ref[i], exp_sig[i], exp_stat[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    per[3] = int'($urandom_range(40, 2));
    settle();
    predict(per[3], 34, exp_ref[3], exp_sig[3], exp_stat[3]);
    pulse_start(4'b1000);
    wait_done(3000, cyc, ok);
    // Restart in the done cycle itself.
    pulse_start(4'b1000);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: got busy=%b, expected 1", busy);
    end
    wait_done(3000, cyc, ok);
    rd_ch = 2'd3;
    #1;
    checks++;
    if (!ok || {rd_ref, rd_sig, rd_stat} !== {exp_ref[3][33:0], exp_sig[3][33:0], exp_stat[3]}) begin
      errors++;
      $display("FAIL b2b_read p=%0d: got done=%b ref=%0d sig=%0d stat=%b, expected 1 %0d %0d %b",
               per[3], ok, rd_ref, rd_sig, rd_stat, exp_ref[3], exp_sig[3], exp_stat[3]);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    bit ok;
    per[2] = 0;
    settle();
    predict(0, 34, exp_ref[2], exp_sig[2], exp_stat[2]);
    pulse_start(4'b0100);
    wait_done(2600, cyc, ok);
    checks++;
    if (!ok || cyc < Tmo || cyc > Tmo + 6) begin
      errors++;
      $display("FAIL timeout_latency: got done=%b after %0d cycles, expected 1 in %0d..%0d",
               ok, cyc, Tmo, Tmo + 6);
    end
    for (int i = 0; i < 4; i++) begin
      rd_ch = 2'(i);
      #1;
      checks++;
      if ({rd_ref, rd_sig, rd_stat} !== {exp_ref[i][33:0], exp_sig[i][33:0], exp_stat[i]}) begin
        errors++;
        $display("FAIL timeout_read ch%0d: got ref=%0d sig=%0d stat=%b, expected %0d %0d %b",
                 i, rd_ref, rd_sig, rd_stat, exp_ref[i], exp_sig[i], exp_stat[i]);
      end
    end
  endtask

  task automatic test_zero_en();
    pulse_start(4'b0000);
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL zero_en_done: got done=%b busy=%b, expected 1 0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_en_pulse: got done=%b, expected 0", done);
    end
    for (int i = 0; i < 4; i++) begin
      rd_ch = 2'(i);
      #1;
      checks++;
      if ({rd_ref, rd_sig, rd_stat} !== {exp_ref[i][33:0], exp_sig[i][33:0], exp_stat[i]}) begin
        errors++;
        $display("FAIL zero_en_keep ch%0d: got ref=%0d sig=%0d stat=%b, expected %0d %0d %b",
                 i, rd_ref, rd_sig, rd_stat, exp_ref[i], exp_sig[i], exp_stat[i]);
      end
    end
  endtask

  task automatic test_ovf();
    int cyc;
    longint unsigned r, s;
    logic [2:0] st;
    predict(2, 8, r, s, st);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0;
    while (cyc < 3000 && done8 !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done8 !== 1'b1 || {rd_ref8, rd_sig8, rd_stat8} !== {r[7:0], s[7:0], st}) begin
      errors++;
      $display("FAIL ovf_read: got done=%b ref=%0d sig=%0d stat=%b, expected 1 %0d %0d %b",
               done8, rd_ref8, rd_sig8, rd_stat8, r, s, st);
    end
  endtask

  task automatic test_cont();
    int cyc, sp;
    bit ok;
    per[0] = 10;
    settle();
    predict(10, 34, exp_ref[0], exp_sig[0], exp_stat[0]);
    cont = 1'b1;
    pulse_start(4'b0001);
    wait_done(3000, cyc, ok);
    for (int k = 0; k < 3; k++) begin
      sp = 0;
      if (k == 1) begin
        repeat (50) @(negedge clk);
        pulse_start(4'b0000);
        sp = 51;
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL cont_ignore_busy: got busy=%b, expected 1", busy);
        end
      end
      wait_done(1300, cyc, ok);
      sp += cyc;
      if (k == 2) cont = 1'b0;
      checks++;
      if (!ok || sp < Gate + 1 || sp > Gate + 15) begin
        errors++;
        $display("FAIL cont_spacing k=%0d: got done=%b spacing=%0d, expected 1 in %0d..%0d",
                 k, ok, sp, Gate + 1, Gate + 15);
      end
      rd_ch = 2'd0;
      #1;
      checks++;
      if ({rd_ref, rd_sig, rd_stat} !== {exp_ref[0][33:0], exp_sig[0][33:0], exp_stat[0]}) begin
        errors++;
        $display("FAIL cont_read k=%0d: got ref=%0d sig=%0d stat=%b, expected %0d %0d %b",
                 k, rd_ref, rd_sig, rd_stat, exp_ref[0], exp_sig[0], exp_stat[0]);
      end
    end
    wait_done(1300, cyc, ok);
    checks++;
    if (ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL cont_stop: got done=%b busy=%b, expected 0 0", ok, busy);
    end
  endtask

  task automatic test_abort_reset();
    int cyc;
    bit ok;
    per[0] = 10;
    settle();
    pulse_start(4'b0001);
    repeat (300) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got busy=%b, expected 0", busy);
    end
    wait_done(1500, cyc, ok);
    rd_ch = 2'd0;
    #1;
    checks++;
    if (ok || {rd_ref, rd_sig, rd_stat} !== {exp_ref[0][33:0], exp_sig[0][33:0], exp_stat[0]}) begin
      errors++;
      $display("FAIL abort_keep: got done=%b ref=%0d sig=%0d stat=%b, expected 0 %0d %0d %b",
               ok, rd_ref, rd_sig, rd_stat, exp_ref[0], exp_sig[0], exp_stat[0]);
    end
    abort = 1'b1;
    pulse_start(4'b0001);
    abort = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL abort_over_start: got busy=%b done=%b, expected 0 0", busy, done);
    end
    pulse_start(4'b0011);
    repeat (300) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got busy=%b, expected 0", busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_ch = 2'(i);
      #1;
      checks++;
      if ({rd_ref, rd_sig, rd_stat, done} !== 72'd0) begin
        errors++;
        $display("FAIL reset_clear ch%0d: got ref=%0d sig=%0d stat=%b done=%b, expected 0 0 000 0",
                 i, rd_ref, rd_sig, rd_stat, done);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      per[i] = 0;
      ph[i] = 0;
    end
    test_reset();
    test_single();
    test_multi(5);
    test_back_to_back();
    test_timeout();
    test_zero_en();
    test_ovf();
    test_cont();
    test_abort_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_meter_mc.md
# freq_meter_mc

Multi-channel equal-precision (reciprocal) frequency meter in the `sys_clk` domain. It is the parametrised successor of the single-channel `freq_cnt_calc` path. Each of `CH` test inputs is synchronised and edge-detected, then gated on its own rising edges so every channel counts whole test periods. For each channel the block returns a reference-cycle count, an edge count and status flags over a register-style read port that the SPI slave glue consumes. The block adds one-shot and continuous modes, per-channel enables, timeout detection and overflow saturation.

## Interface
- `CH`, 4: number of test channels (1..16).
- `CNT_W`, 34: width of both counters per channel.
- `GATE_CYC`, 50_000_000: nominal gate length in `sys_clk` cycles.
- `TIMEOUT_CYC`, 2*GATE_CYC: maximum cycles without a test edge before the channel aborts.
- `SYNC_STAGES`, 2: input synchroniser depth (≥2).

Ports:
- `sys_clk` in 1: single clock. It is the reference for counting.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `sig_in` in CH: raw asynchronous test inputs.
- `ch_en` in CH: channel enables, sampled on `start`.
- `start` in 1: one-cycle measurement request.
- `cont` in 1: 1 selects continuous re-arm after each `done`.
- `abort` in 1: one-cycle pulse that returns every channel to IDLE.
- `busy` out 1: high while any enabled channel is not in DONE.
- `done` out 1: one-cycle pulse when all enabled channels finish.
- `rd_ch` in $clog2(CH): selects the channel for readout.
- `rd_ref` out CNT_W: latched reference count of the selected channel.
- `rd_sig` out CNT_W: latched edge count of the selected channel.
- `rd_stat` out 3: {ovf, timeout, valid} of the selected channel.

## Operation
- Each `sig_in[i]` passes through `SYNC_STAGES` flops, then a rising-edge detector producing `edge_i`.
- Per-channel FSM states:
  - IDLE → ARM on accepted `start` with `ch_en[i]`=1. Disabled channels stay IDLE and keep their last results.
  - ARM → COUNT on the first `edge_i`. The reference and signal counters clear to 0 and the gate timer starts.
  - COUNT: `ref_cnt` increments every cycle and `sig_cnt` increments on each `edge_i`. When the gate timer reaches `GATE_CYC`, go to CLOSE.
  - CLOSE → DONE on the next `edge_i`. That edge is included in `sig_cnt`, and `ref_cnt` includes that cycle. Both counters are latched into the result registers with valid=1.
  - In ARM, COUNT or CLOSE, if `TIMEOUT_CYC` cycles pass since the last edge (or since arming), go to DONE with valid=0 and timeout=1. Results latch as 0.
  - DONE holds until the next accepted `start`, or until the auto-restart when `cont`=1.
- Frequency is computed outside the block as f_sig = f_sys·sig_cnt/ref_cnt.
- Counters saturate at 2^CNT_W−1 and set the sticky ovf flag for that measurement. valid is still asserted.
- `start` while `busy`=1 is ignored. `start` with `ch_en`=0 produces `done` on the next cycle with no results changed.
- `abort` takes priority over `start` in the same cycle. It sends every channel to IDLE, latched results are unchanged, and no `done` is produced.
- Continuous mode: the cycle after `done`, all channels enabled in the last `ch_en` sample re-arm without a new `start`.

## Timing
- Reset values: all FSMs IDLE, all counters and result registers 0, `busy`=0, `done`=0, `rd_ref`=`rd_sig`=0, `rd_stat`=0.
- A rising input edge appears as `edge_i` SYNC_STAGES+1 cycles later. All channels see the same latency, so ratios are unaffected.
- Results latch on the clock edge where the closing `edge_i` is sampled. `done` goes high 1 cycle after the last enabled channel enters DONE. `busy` falls in the same cycle as `done`.
- The read port is a combinational mux of latched registers. Data is stable from `done` until the next channel completion.
- ±1 `ref_cnt` quantisation only. There is no test-side gating error.

## Structure
- `freq_meter_pkg` holds:
  - the channel FSM state enum (IDLE, ARM, COUNT, CLOSE, DONE);
  - the status bit indices (VALID=0, TIMEOUT=1, OVF=2).
- Sub-module `freq_meter_chan` contains the synchroniser, edge detector, FSM, counters, gate timer, timeout timer and result registers.
- The top level generates `CH` instances and adds the start/abort/cont arbitration, the `done`/`busy` aggregation and the read mux.

## Test plan
Simulation values: GATE_CYC=1000, TIMEOUT_CYC=2000.
- Ch0 period 10 cycles, one-shot `start` → `done` pulse; rd_ch=0 gives `rd_ref`=1000, `rd_sig`=100, `rd_stat`=3'b001.
- Ch1 period 7 cycles → `rd_ref`=1001, `rd_sig`=143, valid; ch0 enabled together with it is unaffected.
- Ch2 held low, `ch_en`=4'b0100 → `done` 2000 cycles after `start` (+ sync latency), `rd_stat`=3'b010, counts 0.
- CNT_W=8, ch0 period 2 cycles → `rd_ref`=255, `rd_stat`=3'b101.
- `cont`=1, ch0 period 10 → `done` repeats every ~1000+SYNC cycles with identical results; a second `start` while busy is ignored.
- `abort` mid-COUNT, then assert `sys_rst_n`=0 mid-measurement → `busy`=0 immediately; after reset all read outputs are 0.
